// File: rtl/muldiv_unit.sv
// Iterative MIPS-style multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, 32 iterations; optional single-cycle multiply.
module muldiv_unit #(
    parameter bit FAST_MUL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE, CALC} state_t;

    state_t      state;
    logic [63:0] work;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] opnd_b;    // multiplicand or divisor magnitude
    logic [4:0]  counter;
    logic        is_div;
    logic        neg_lo;
    logic        neg_hi;

    function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic is_signed);
        logic [31:0] m;
        m = v;
        if (is_signed && v[31])
            m = ~v + 32'd1;
        return m;
    endfunction

    function automatic logic [31:0] apply_sign32(input logic [31:0] m, input logic neg);
        return neg ? (~m + 32'd1) : m;
    endfunction

    function automatic logic [63:0] apply_sign64(input logic [63:0] m, input logic neg);
        return neg ? (~m + 64'd1) : m;
    endfunction

    logic        acc_signed;
    logic        sign_a;
    logic        sign_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] rem_sh;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] step_next;
    logic [63:0] fast_prod;
    logic        fast_path;
    logic        finish;
    logic [63:0] final_raw;

    always_comb begin
        acc_signed = ~op[0];
        sign_a     = acc_signed & src_a[31];
        sign_b     = acc_signed & src_b[31];

        mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, opnd_b} : 33'd0);
        mul_next = {mul_sum, work[31:1]};

        // Remainder always stays below the divisor, so a 33-bit trial subtract suffices.
        rem_sh   = {work[63:32], work[31]};
        div_diff = rem_sh - {1'b0, opnd_b};
        div_next = div_diff[32] ? {rem_sh[31:0], work[30:0], 1'b0}
                                : {div_diff[31:0], work[30:0], 1'b1};

        step_next = is_div ? div_next : mul_next;
        fast_prod = 64'(work[31:0]) * 64'(opnd_b);
        fast_path = FAST_MUL && !is_div;
        finish    = fast_path || (counter == 5'd31);
        final_raw = fast_path ? fast_prod : step_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            work    <= 64'd0;
            opnd_b  <= 32'd0;
            counter <= 5'd0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && !cancel) begin
                    case (op)
                        OP_MTHI: hi <= src_a;
                        OP_MTLO: lo <= src_a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            work    <= {32'd0, magnitude(src_a, acc_signed)};
                            opnd_b  <= magnitude(src_b, acc_signed);
                            is_div  <= op[1];
                            // Divide by zero keeps the all-ones quotient unsigned.
                            neg_lo  <= (sign_a ^ sign_b) & (|src_b);
                            neg_hi  <= sign_a;
                            counter <= 5'd0;
                            state   <= CALC;
                            busy    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else begin
                if (cancel) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else if (finish) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (is_div) begin
                        lo <= apply_sign32(final_raw[31:0], neg_lo);
                        hi <= apply_sign32(final_raw[63:32], neg_hi);
                    end else begin
                        {hi, lo} <= apply_sign64(final_raw, neg_lo);
                    end
                end else begin
                    work    <= step_next;
                    counter <= counter + 5'd1;
                end
            end
        end
    end

endmodule
